// File: rtl/hood_pkg.sv
// Shared types and constants for the range-hood controller and its
// usage monitor.
package hood_pkg;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_L1   = 2'b01;
  localparam logic [1:0] MODE_L2   = 2'b10;
  localparam logic [1:0] MODE_L3   = 2'b11;

  localparam logic [6:0] MAX_H  = 7'd99;
  localparam logic [5:0] MAX_MS = 6'd59;

  typedef enum logic [1:0] {
    MON_MONITOR  = 2'd0,
    MON_REMIND   = 2'd1,
    MON_CLEANING = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic [1:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
  } cd_bcd_t;

  function automatic cd_bcd_t to_bcd(input logic [7:0] v);
    cd_bcd_t    b;
    logic [7:0] r;
    logic [7:0] t8;
    logic [7:0] o8;
    if (v >= 8'd200) begin
      b.hund = 2'd2;
      r      = v - 8'd200;
    end else if (v >= 8'd100) begin
      b.hund = 2'd1;
      r      = v - 8'd100;
    end else begin
      b.hund = 2'd0;
      r      = v;
    end
    t8     = r / 8'd10;
    o8     = r % 8'd10;
    b.tens = t8[3:0];
    b.ones = o8[3:0];
    return b;
  endfunction

endpackage

// File: rtl/hood_usage_monitor_if.sv
// Status bundle between the fan controller side and the usage
// monitor, plus the monitor's display/reminder outputs.
interface hood_usage_monitor_if;
  logic       is_on;
  logic [1:0] mode;
  logic       busy;
  logic [7:0] countdown;
  logic       countdown_active;
  logic       clean_key;
  logic       sec_tick;
  logic [6:0] run_h;
  logic [5:0] run_m;
  logic [5:0] run_s;
  logic       clean_remind;
  logic       cleaning_active;
  logic [7:0] hurricane_cnt;
  logic [1:0] cd_hund;
  logic [3:0] cd_tens;
  logic [3:0] cd_ones;
  logic       cd_valid;

  modport master (
    output is_on, mode, busy, countdown,
    output countdown_active, clean_key,
    input  sec_tick, run_h, run_m, run_s,
    input  clean_remind, cleaning_active,
    input  hurricane_cnt, cd_hund, cd_tens,
    input  cd_ones, cd_valid
  );

  modport slave (
    input  is_on, mode, busy, countdown,
    input  countdown_active, clean_key,
    output sec_tick, run_h, run_m, run_s,
    output clean_remind, cleaning_active,
    output hurricane_cnt, cd_hund, cd_tens,
    output cd_ones, cd_valid
  );
endinterface

// File: rtl/hood_sec_prescaler.sv
// Free-running divider producing a one-cycle pulse
// once every CLK_HZ clocks.
module hood_sec_prescaler #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic sec_tick
);
  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // advance the count, wrapping after the last cycle of each second
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) cnt_d = '0;
  end

  // prescaler phase register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign sec_tick = (cnt_q == LAST);
endmodule

// File: rtl/hood_usage_monitor.sv
// Fan run-time accumulator, filter-cleaning reminder FSM,
// hurricane-entry counter and countdown BCD conversion.
module hood_usage_monitor
  import hood_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int REMIND_SEC     = 36000,
  parameter int CLEAN_HOLD_SEC = 3
) (
  input logic                 clk,
  input logic                 rst,
  hood_usage_monitor_if.slave bus
);
  localparam logic [23:0] REMIND_TOT = 24'(REMIND_SEC);
  localparam logic [15:0] HOLD_INIT  = 16'(CLEAN_HOLD_SEC);

  logic        sec_tick;
  mon_state_e  state_q, state_d;
  logic [6:0]  run_h_q, run_h_d;
  logic [5:0]  run_m_q, run_m_d;
  logic [5:0]  run_s_q, run_s_d;
  logic [23:0] total_q, total_d;
  logic [15:0] hold_q, hold_d;
  logic [1:0]  mode_q, mode_qq;
  logic [7:0]  hur_q, hur_d;
  cd_bcd_t     bcd_q, bcd_d;
  logic        cdv_q;
  logic        accept;
  logic        run_en;
  logic        at_max;

  hood_sec_prescaler #(.CLK_HZ(CLK_HZ)) u_presc (
    .clk      (clk),
    .rst      (rst),
    .sec_tick (sec_tick)
  );

  // next state, run-time counters and cleaning hold timer
  always_comb begin
    state_d = state_q;
    run_h_d = run_h_q;
    run_m_d = run_m_q;
    run_s_d = run_s_q;
    total_d = total_q;
    hold_d  = hold_q;
    accept  = bus.clean_key && (bus.mode == MODE_IDLE)
           && !bus.busy && (state_q != MON_CLEANING);
    run_en  = sec_tick && bus.busy && bus.is_on
           && (state_q != MON_CLEANING) && !accept;
    at_max  = (run_h_q == MAX_H) && (run_m_q == MAX_MS)
           && (run_s_q == MAX_MS);

    if (accept) begin
      run_h_d = '0;
      run_m_d = '0;
      run_s_d = '0;
      total_d = '0;
      hold_d  = HOLD_INIT;
    end else if (run_en) begin
      if (total_q != '1) total_d = total_q + 24'd1;
      if (!at_max) begin
        if (run_s_q == MAX_MS) begin
          run_s_d = '0;
          if (run_m_q == MAX_MS) begin
            run_m_d = '0;
            run_h_d = run_h_q + 7'd1;
          end else begin
            run_m_d = run_m_q + 6'd1;
          end
        end else begin
          run_s_d = run_s_q + 6'd1;
        end
      end
    end

    unique case (state_q)
      MON_MONITOR: begin
        if (accept)                     state_d = MON_CLEANING;
        else if (total_d == REMIND_TOT) state_d = MON_REMIND;
      end
      MON_REMIND: begin
        if (accept) state_d = MON_CLEANING;
      end
      MON_CLEANING: begin
        if (sec_tick) begin
          if (hold_q <= 16'd1) begin
            hold_d  = '0;
            state_d = MON_MONITOR;
          end else begin
            hold_d = hold_q - 16'd1;
          end
        end
      end
      default: state_d = MON_MONITOR;
    endcase
  end

  // FSM and run-time state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MON_MONITOR;
      run_h_q <= '0;
      run_m_q <= '0;
      run_s_q <= '0;
      total_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      run_h_q <= run_h_d;
      run_m_q <= run_m_d;
      run_s_q <= run_s_d;
      total_q <= total_d;
      hold_q  <= hold_d;
    end
  end

  // count rising entries into hurricane mode, saturating
  always_comb begin
    hur_d = hur_q;
    if ((mode_qq != MODE_L3) && (mode_q == MODE_L3)
        && (hur_q != 8'hff))
      hur_d = hur_q + 8'd1;
  end

  // mode sample pipeline and hurricane counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_IDLE;
      mode_qq <= MODE_IDLE;
      hur_q   <= '0;
    end else begin
      mode_q  <= bus.mode;
      mode_qq <= mode_q;
      hur_q   <= hur_d;
    end
  end

  // BCD digits only while the countdown is valid
  always_comb begin
    bcd_d = '0;
    if (bus.countdown_active) bcd_d = to_bcd(bus.countdown);
  end

  // registered display digits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q <= '0;
      cdv_q <= 1'b0;
    end else begin
      bcd_q <= bcd_d;
      cdv_q <= bus.countdown_active;
    end
  end

  assign bus.sec_tick        = sec_tick;
  assign bus.run_h           = run_h_q;
  assign bus.run_m           = run_m_q;
  assign bus.run_s           = run_s_q;
  assign bus.clean_remind    = (state_q == MON_REMIND);
  assign bus.cleaning_active = (state_q == MON_CLEANING);
  assign bus.hurricane_cnt   = hur_q;
  assign bus.cd_hund         = bcd_q.hund;
  assign bus.cd_tens         = bcd_q.tens;
  assign bus.cd_ones         = bcd_q.ones;
  assign bus.cd_valid        = cdv_q;
endmodule

// File: tb/tb_hood_usage_monitor.sv
// Directed bench for hood_usage_monitor with CLK_HZ=10,
// REMIND_SEC=5, CLEAN_HOLD_SEC=3.
module tb_hood_usage_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  hood_usage_monitor_if bus ();

  hood_usage_monitor #(
    .CLK_HZ         (10),
    .REMIND_SEC     (5),
    .CLEAN_HOLD_SEC (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input int unsigned got,
                       input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // wait for the next sec_tick, then one more negedge so the
  // update it caused is visible
  task automatic wait_tick(input string tag);
    int n = 0;
    while (!bus.sec_tick && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.sec_tick) check({tag, "_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  task automatic pulse_key();
    bus.clean_key = 1'b1;
    @(negedge clk);
    bus.clean_key = 1'b0;
  endtask

  function automatic int unsigned hms();
    return bus.run_h * 10000 + bus.run_m * 100 + bus.run_s;
  endfunction

  function automatic int unsigned bcd3();
    return bus.cd_valid * 1000 + bus.cd_hund * 100
         + bus.cd_tens * 10 + bus.cd_ones;
  endfunction

  initial begin
    int first;
    bus.is_on            = 1'b0;
    bus.mode             = 2'b00;
    bus.busy             = 1'b0;
    bus.countdown        = 8'd0;
    bus.countdown_active = 1'b0;
    bus.clean_key        = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_hms", hms(), 0);
    check("rst_remind", bus.clean_remind, 0);
    check("rst_clean", bus.cleaning_active, 0);
    check("rst_hur", bus.hurricane_cnt, 0);
    check("rst_bcd", bcd3(), 0);
    check("rst_tick", bus.sec_tick, 0);
    @(negedge clk);
    first = -1;
    for (int i = 1; i < 12; i++) begin
      if (bus.sec_tick && first < 0) first = i;
      @(negedge clk);
    end
    check("first_tick", first, 9);
    check("idle_hms", hms(), 0);

    bus.busy  = 1'b1;
    bus.is_on = 1'b1;
    bus.mode  = 2'b01;
    repeat (4) wait_tick("acc");
    check("run_s4", bus.run_s, 4);
    check("remind_s4", bus.clean_remind, 0);
    for (int n = 0; n < 30 && !bus.sec_tick; n++) @(negedge clk);
    check("remind_pre", bus.clean_remind, 0);
    @(negedge clk);
    check("remind_rise", bus.clean_remind, 1);
    check("run_s5", bus.run_s, 5);
    wait_tick("acc6");
    check("run_s6", bus.run_s, 6);

    pulse_key();
    check("key_busy_ign", bus.cleaning_active, 0);
    check("key_busy_rem", bus.clean_remind, 1);
    bus.busy = 1'b0;
    bus.mode = 2'b00;
    @(negedge clk);
    pulse_key();
    check("clean_enter", bus.cleaning_active, 1);
    check("clean_hms0", hms(), 0);
    check("clean_rem0", bus.clean_remind, 0);
    wait_tick("cl1");
    pulse_key();
    check("clean_t1", bus.cleaning_active, 1);
    wait_tick("cl2");
    check("clean_t2", bus.cleaning_active, 1);
    wait_tick("cl3");
    check("clean_exit", bus.cleaning_active, 0);
    check("clean_exit_rem", bus.clean_remind, 0);

    rst = 1'b1;
    #2;
    check("midrst_clean", bus.cleaning_active, 0);
    @(negedge clk);
    rst = 1'b0;
    force dut.run_h_q = 7'd99;
    force dut.run_m_q = 6'd59;
    force dut.run_s_q = 6'd58;
    #1;
    release dut.run_h_q;
    release dut.run_m_q;
    release dut.run_s_q;
    bus.busy  = 1'b1;
    bus.is_on = 1'b1;
    bus.mode  = 2'b01;
    wait_tick("sat1");
    check("sat_59", hms(), 995959);
    repeat (2) wait_tick("sat2");
    check("sat_hold", hms(), 995959);
    check("sat_rem", bus.clean_remind, 0);

    force dut.run_h_q = 7'd0;
    force dut.run_m_q = 6'd0;
    force dut.run_s_q = 6'd59;
    #1;
    release dut.run_h_q;
    release dut.run_m_q;
    release dut.run_s_q;
    wait_tick("carry_s");
    check("carry_s", hms(), 100);
    bus.is_on = 1'b0;
    wait_tick("off");
    check("off_hold", hms(), 100);
    bus.is_on = 1'b1;
    force dut.run_m_q = 6'd59;
    force dut.run_s_q = 6'd59;
    #1;
    release dut.run_m_q;
    release dut.run_s_q;
    wait_tick("carry_m");
    check("carry_m", hms(), 10000);
    check("remind_2", bus.clean_remind, 1);

    bus.mode = 2'b00;
    @(negedge clk);
    bus.mode = 2'b11;
    @(negedge clk);
    bus.mode = 2'b10;
    @(negedge clk);
    bus.mode = 2'b11;
    @(negedge clk);
    @(negedge clk);
    repeat (2) @(negedge clk);
    check("hur_seq", bus.hurricane_cnt, 2);
    bus.mode = 2'b00;
    repeat (2) @(negedge clk);
    bus.mode = 2'b11;
    @(negedge clk);
    check("hur_lat1", bus.hurricane_cnt, 2);
    @(negedge clk);
    check("hur_lat2", bus.hurricane_cnt, 3);
    for (int i = 0; i < 260; i++) begin
      bus.mode = 2'b00;
      @(negedge clk);
      bus.mode = 2'b11;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("hur_sat", bus.hurricane_cnt, 255);

    bus.countdown        = 8'd60;
    bus.countdown_active = 1'b1;
    @(negedge clk);
    check("bcd_60", bcd3(), 1060);
    bus.countdown = 8'd255;
    #1;
    check("bcd_lat", bcd3(), 1060);
    @(negedge clk);
    check("bcd_255", bcd3(), 1255);
    bus.countdown = 8'd109;
    @(negedge clk);
    check("bcd_109", bcd3(), 1109);
    bus.countdown = 8'd200;
    @(negedge clk);
    check("bcd_200", bcd3(), 1200);
    bus.countdown_active = 1'b0;
    @(negedge clk);
    check("bcd_off", bcd3(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
